// File: rtl/iob_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// iob_fifo_wr_arb
//
// Round-robin burst arbiter that lets N write requesters share the write port
// of a single FIFO. A requester raises req together with a burst length (field
// value L means L+1 words). Once it wins, it owns the FIFO write port until all
// of its words have been written. Data moves one word per cycle whenever the
// owner presents valid data and the FIFO is not full.
//
// Optional feature (macro IOB_FIFO_WR_ARB_SPACE_CHECK_EN):
//   When defined, a winner whose burst does not fit in the free FIFO space
//   waits in WAIT (still holding the arbitration win) until the space is
//   there, so that a burst is never split by full-flag stalls. When undefined,
//   the winner is granted immediately and full stalls are simply tolerated.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   req           per-requester burst request                  [N]
//   len           per-requester burst length field             [N*BURST_W]
//   d_data        per-requester write data                     [N*DATA_W]
//   d_valid       per-requester data valid                     [N]
//   d_ready       per-requester word-accepted strobe           [N]
//   grant         one-hot current owner, zero when no burst    [N]
//   busy          burst in progress
//   fifo_w_en     FIFO write enable
//   fifo_w_data   FIFO write data                              [DATA_W]
//   fifo_w_full   FIFO full flag
//   fifo_w_level  FIFO occupancy in write-width words          [ADDR_W+1]
// ---------------------------------------------------------------------------
module iob_fifo_wr_arb #(
  parameter int N       = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int BURST_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req,
  input  logic [N*BURST_W-1:0]   len,
  input  logic [N*DATA_W-1:0]    d_data,
  input  logic [N-1:0]           d_valid,
  output logic [N-1:0]           d_ready,
  output logic [N-1:0]           grant,
  output logic                   busy,
  output logic                   fifo_w_en,
  output logic [DATA_W-1:0]      fifo_w_data,
  input  logic                   fifo_w_full,
  input  logic [ADDR_W:0]        fifo_w_level
);

  localparam int IW = $clog2(N);
  // Word counter must hold L+1 for the largest length field.
  localparam int WW = BURST_W + 1;
  // Space comparison width: wide enough for both the word count and the
  // full-FIFO capacity 2^ADDR_W, plus headroom for the subtraction.
  localparam int CW = ((WW > ADDR_W + 1) ? WW : ADDR_W + 1) + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [WW-1:0]   wordsLeft_q, wordsLeft_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            busy_q, busy_d;

  logic            anyReq;
  logic            found;
  int              scanIdx;
  logic [IW-1:0]   winIdx;
  logic [WW-1:0]   winWords;
  logic [IW-1:0]   nextPtr;
  logic            spaceOk;

  // Round-robin search: first asserted request at or above ptr, wrapping.
  always_comb begin
    found   = 1'b0;
    scanIdx = 0;
    winIdx  = '0;
    for (int k = 0; k < N; k++) begin
      scanIdx = (int'(ptr_q) + k) % N;
      if (!found && req[scanIdx]) begin
        found  = 1'b1;
        winIdx = IW'(scanIdx);
      end
    end
  end

  assign anyReq   = |req;
  assign winWords = WW'(len[winIdx*BURST_W +: BURST_W]) + WW'(1);
  assign nextPtr  = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;

`ifdef IOB_FIFO_WR_ARB_SPACE_CHECK_EN
  // In IDLE the candidate is the fresh winner; in WAIT it is the latched one,
  // whose full length is still held in wordsLeft_q.
  logic [WW-1:0] needWords;
  logic [CW-1:0] spaceLeft;
  assign needWords = (state_q == IDLE) ? winWords : wordsLeft_q;
  assign spaceLeft = CW'(2 ** ADDR_W) - CW'(fifo_w_level);
  assign spaceOk   = (CW'(needWords) <= spaceLeft);
`else
  logic unusedLevel;
  assign unusedLevel = ^fifo_w_level;
  assign spaceOk     = 1'b1;
`endif

  // The write path is combinational from the registered grant so a word is
  // accepted in the same cycle its valid is seen; reset blocks it at once.
  assign d_ready     = grant_q & d_valid & {N{~fifo_w_full & ~rst}};
  assign fifo_w_en   = |d_ready;
  assign fifo_w_data = d_data[owner_q*DATA_W +: DATA_W];
  assign grant       = grant_q;
  assign busy        = busy_q;

  // Next-state logic: latch the winner in IDLE, optionally park in WAIT, and
  // count down accepted words in BURST. Returning to IDLE on the last word
  // forces one idle cycle before the next grant.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    wordsLeft_d = wordsLeft_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          owner_d     = winIdx;
          wordsLeft_d = winWords;
          if (spaceOk) begin
            state_d = BURST;
            grant_d = N'(1) << winIdx;
            busy_d  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (spaceOk) begin
          state_d = BURST;
          grant_d = N'(1) << owner_q;
          busy_d  = 1'b1;
        end
      end
      BURST: begin
        if (fifo_w_en) begin
          if (wordsLeft_q == WW'(1)) begin
            state_d     = IDLE;
            grant_d     = '0;
            busy_d      = 1'b0;
            ptr_d       = nextPtr;
            wordsLeft_d = '0;
          end else begin
            wordsLeft_d = wordsLeft_q - WW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset discards any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      wordsLeft_q <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      wordsLeft_q <= wordsLeft_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: doc/iob_fifo_wr_arb.md
IOB_FIFO_WR_ARB -- requirements
Module: iob_fifo_wr_arb

Interface
REQ-001 SHALL have parameter N, default 4: number of write requesters, N >= 2.
REQ-002 SHALL have parameter DATA_W, default 32: FIFO write-port data width.
REQ-003 SHALL have parameter ADDR_W, default 4: FIFO depth is 2^ADDR_W write-width words.
REQ-004 SHALL have parameter BURST_W, default 3: burst-length field width.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- req  input  N  per-requester burst request
- len  input  N*BURST_W  per-requester burst length; field value L means L+1 words
- d_data  input  N*DATA_W  per-requester write data
- d_valid  input  N  per-requester data valid
- d_ready  output  N  per-requester word-accepted strobe
- grant  output  N  one-hot (or zero) current owner
- busy  output  1  burst in progress
- fifo_w_en  output  1  FIFO write enable
- fifo_w_data  output  DATA_W  FIFO write data
- fifo_w_full  input  1  FIFO full flag
- fifo_w_level  input  ADDR_W+1  FIFO occupancy in write-width words

Function
REQ-006 SHALL implement states IDLE, WAIT and BURST.
REQ-007 SHALL arbitrate round-robin with pointer ptr: the winner is the first asserted req[i] searching from ptr upward, modulo N.
REQ-008 SHALL latch the winner index and its len+1 in IDLE when any req is set, entering BURST next edge (grant visible 1 cycle after req sampled), or WAIT per REQ-016.
REQ-009 SHALL, in BURST, drive fifo_w_data = d_data[g] and fifo_w_en = d_ready[g] = d_valid[g] & ~fifo_w_full & ~rst; d_ready of non-owners SHALL be 0.
REQ-010 SHALL count accepted words; on the edge accepting the last word it SHALL clear grant, set ptr = (g+1) mod N and return to IDLE.
REQ-011 SHALL leave one IDLE cycle between consecutive bursts.
REQ-012 SHALL ignore req deassertion and len changes during BURST; the latched burst always completes.
REQ-013 SHALL hold the burst with no write and no word count while fifo_w_full=1; no word is lost or duplicated.
REQ-014 SHALL set busy = 1 exactly in BURST; grant SHALL be non-zero only in BURST.

Reset
REQ-015 SHALL, on rst at a rising edge, set state=IDLE, ptr=0, count=0, grant=0 and busy=0; fifo_w_en and d_ready SHALL be 0 while rst=1, including mid-burst; the aborted burst is discarded.

Configuration
REQ-016 SHALL, with IOB_FIFO_WR_ARB_SPACE_CHECK_EN defined, enter WAIT instead of BURST when the winner's words exceed 2^ADDR_W - fifo_w_level; WAIT holds the latched winner (no skipping) and enters BURST on the first edge where space suffices.
REQ-017 SHALL, without the macro, never enter WAIT, granting immediately and relying on REQ-013 stalling.

Verification (N=4, DATA_W=32, ADDR_W=4, BURST_W=3)
REQ-018 Single requester: req[0]=1, len=3, data 0xA0..0xA3 always valid -> grant[0] 1 cycle later; 4 consecutive fifo_w_en with 0xA0,0xA1,0xA2,0xA3; then grant=0, busy=0.
REQ-019 Fairness: all req set, len=1 each, held -> grant order 0,1,2,3,0 with 2-word bursts and one idle cycle between.
REQ-020 Backpressure: fifo_w_full=1 for 5 cycles after 2nd word of a 4-word burst -> fifo_w_en=d_ready=0 those 5 cycles; words 3,4 written afterwards exactly once.
REQ-021 Space check, macro on: fifo_w_level=14, req[1] with len=3 -> WAIT, grant=0 until level<=12, then BURST; macro off -> grant next cycle, stall on full.
REQ-022 Reset mid-burst: rst=1 at word 2 of req[2] burst -> fifo_w_en=0 that cycle, then grant=0 and ptr=0; after release, req[0] and req[1] set together -> grant[0] first.
REQ-023 Request drop: req[3] deasserted after 1st of 4 words -> all 4 words still written, grant[3] held until the last.
